// File: rtl/drift_correction_scheduler_if.sv
// Shared direction type and the phase-adjust port of the recovered-clock
// generator, as seen from the scheduler (master) and the generator (slave).

package drift_correction_pkg;
    typedef enum logic {
        PIN_CAME_EARLY = 1'b0,
        PIN_CAME_LATE  = 1'b1
    } drift_direction_e;
endpackage

interface drift_correction_scheduler_if #(
    parameter int LANE_W = 2
);
    logic                                  adj_req_o;
    logic                                  adj_res_i;
    drift_correction_pkg::drift_direction_e adj_direction_o;
    logic [LANE_W-1:0]                     adj_lane_o;

    modport master (
        output adj_req_o,
        output adj_direction_o,
        output adj_lane_o,
        input  adj_res_i
    );

    modport slave (
        input  adj_req_o,
        input  adj_direction_o,
        input  adj_lane_o,
        output adj_res_i
    );
endinterface

// File: rtl/drift_correction_scheduler.sv
// Round-robin scheduler sharing one phase-adjust port among NUM_LANES drift
// accumulators. One single-step correction is in flight at a time; each
// accepted step is followed by a programmable quiet (holdoff) period. Lanes
// reporting overflow or inverse-drift violations are fenced off until cleared.

module drift_correction_scheduler
    import drift_correction_pkg::*;
#(
    parameter int NUM_LANES     = 4,
    parameter int HOLDOFF_WIDTH = 8,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                                clk,
    input  logic                                arst,
    input  logic                                clk_en,
    input  logic                                scheduler_en_i,
    input  logic                                clear_state_i,
    input  logic [HOLDOFF_WIDTH-1:0]            holdoff_cycles_i,
    input  logic [NUM_LANES-1:0]                lane_drift_req_i,
    input  drift_direction_e [NUM_LANES-1:0]    lane_drift_direction_i,
    input  logic [NUM_LANES-1:0]                lane_overflow_i,
    input  logic [NUM_LANES-1:0]                lane_inverse_violation_i,
    output logic [NUM_LANES-1:0]                lane_drift_res_o,
    output logic [NUM_LANES-1:0]                lane_fault_o,
    drift_correction_scheduler_if.master        adj_if,
    output logic                                busy_o,
    output logic [COUNT_WIDTH-1:0]              correction_count_o
);

    localparam int LANE_W = $clog2(NUM_LANES);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // State registers and their next-state values
    // ------------------------------------------------------------------
    state_e                     state_q,    state_d;
    logic [LANE_W-1:0]          rr_q,       rr_d;
    logic                       adj_req_q,  adj_req_d;
    logic [LANE_W-1:0]          adj_lane_q, adj_lane_d;
    drift_direction_e           adj_dir_q,  adj_dir_d;
    logic [HOLDOFF_WIDTH-1:0]   hold_q,     hold_d;
    logic [COUNT_WIDTH-1:0]     count_q,    count_d;
    logic [NUM_LANES-1:0]       fault_q,    fault_d;

    // ------------------------------------------------------------------
    // Arbitration helpers
    // ------------------------------------------------------------------
    logic [NUM_LANES-1:0]       elig;
    logic                       grant_found;
    logic [LANE_W-1:0]          grant_idx;
    logic                       handshake;

    // First eligible lane at or after the round-robin pointer, wrapping
    // upward. Returns {found, index}.
    function automatic logic [LANE_W:0] pick_lane(
        input logic [NUM_LANES-1:0] eligible,
        input logic [LANE_W-1:0]    start
    );
        logic [LANE_W:0] result;
        int              idx;
        result = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            idx = int'(start) + k;
            if (idx >= NUM_LANES) begin
                idx = idx - NUM_LANES;
            end
            if (!result[LANE_W] && eligible[idx]) begin
                result = {1'b1, LANE_W'(idx)};
            end
        end
        return result;
    endfunction

    // Next lane after the one just serviced, wrapping for any lane count.
    function automatic logic [LANE_W-1:0] next_lane(input logic [LANE_W-1:0] lane);
        if (int'(lane) == NUM_LANES - 1) begin
            return '0;
        end
        return lane + LANE_W'(1);
    endfunction

    // Faulted lanes never compete, whatever they request.
    assign elig = lane_drift_req_i & ~fault_q;

    // Round-robin pick from the current eligible set.
    always_comb begin
        {grant_found, grant_idx} = pick_lane(elig, rr_q);
    end

    // A step is accepted only on an enabled cycle while the request is up.
    assign handshake = adj_req_q & adj_if.adj_res_i & clk_en;

    // Accept strobe is combinational so the lane sees it in the accept cycle.
    always_comb begin
        lane_drift_res_o = '0;
        if (handshake) begin
            lane_drift_res_o = NUM_LANES'(1) << adj_lane_q;
        end
    end

    // Scheduler FSM: next state, arbitration, counters and fault tracking.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves a value unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        rr_d       = rr_q;
        adj_req_d  = adj_req_q;
        adj_lane_d = adj_lane_q;
        adj_dir_d  = adj_dir_q;
        hold_d     = hold_q;
        count_d    = count_q;

        // Clear wins over a fault arriving in the same cycle.
        if (clear_state_i) begin
            fault_d = '0;
        end else begin
            fault_d = fault_q | lane_overflow_i | lane_inverse_violation_i;
        end

        unique case (state_q)
            ST_IDLE: begin
                // Clear abandons arbitration for this cycle.
                if (scheduler_en_i && grant_found && !clear_state_i) begin
                    state_d    = ST_ISSUE;
                    adj_req_d  = 1'b1;
                    adj_lane_d = grant_idx;
                    adj_dir_d  = lane_drift_direction_i[grant_idx];
                end
            end

            ST_ISSUE: begin
                // The grant is never revoked: request, lane and direction hold
                // until the generator accepts, even if the lane drops or faults.
                if (handshake) begin
                    adj_req_d = 1'b0;
                    rr_d      = next_lane(adj_lane_q);
                    if (count_q != '1) begin
                        count_d = count_q + COUNT_WIDTH'(1);
                    end
                    if (holdoff_cycles_i == '0 || clear_state_i) begin
                        state_d = ST_IDLE;
                        hold_d  = '0;
                    end else begin
                        state_d = ST_HOLDOFF;
                        hold_d  = holdoff_cycles_i;
                    end
                end
            end

            ST_HOLDOFF: begin
                // Counter value N gives exactly N enabled cycles of quiet.
                if (clear_state_i || hold_q <= HOLDOFF_WIDTH'(1)) begin
                    state_d = ST_IDLE;
                    hold_d  = '0;
                end else begin
                    hold_d  = hold_q - HOLDOFF_WIDTH'(1);
                end
            end

            default: begin
                state_d   = ST_IDLE;
                adj_req_d = 1'b0;
                hold_d    = '0;
            end
        endcase
    end

    // State register: async reset, otherwise advance only on enabled cycles.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q    <= ST_IDLE;
            rr_q       <= '0;
            adj_req_q  <= 1'b0;
            adj_lane_q <= '0;
            adj_dir_q  <= PIN_CAME_EARLY;
            hold_q     <= '0;
            count_q    <= '0;
            fault_q    <= '0;
        end else if (clk_en) begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q    <= state_d;
            rr_q       <= rr_d;
            adj_req_q  <= adj_req_d;
            adj_lane_q <= adj_lane_d;
            adj_dir_q  <= adj_dir_d;
            hold_q     <= hold_d;
            count_q    <= count_d;
            fault_q    <= fault_d;
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    assign adj_if.adj_req_o       = adj_req_q;
    assign adj_if.adj_lane_o      = adj_lane_q;
    assign adj_if.adj_direction_o = adj_dir_q;
    assign lane_fault_o           = fault_q;
    assign correction_count_o     = count_q;
    assign busy_o                 = (state_q != ST_IDLE);

    // ------------------------------------------------------------------
    // Handshake legality
    // ------------------------------------------------------------------
    // At most one lane is ever told its step was accepted.
    a_res_onehot: assert property (@(posedge clk) disable iff (arst)
        $onehot0(lane_drift_res_o));

    // An accept strobe only ever accompanies an outstanding request.
    a_res_needs_req: assert property (@(posedge clk) disable iff (arst)
        (lane_drift_res_o != '0) |-> adj_req_q);

endmodule

// File: tb/tb_drift_correction_scheduler.sv
// Self-checking bench for drift_correction_scheduler: a transaction table for
// round-robin grants plus hand-written sequences for stalls, faults, clock
// enable gating, saturation and asynchronous reset. Accepted corrections are
// checked against a scoreboard queue of expected {lane, direction}.

module tb_drift_correction_scheduler;
    import drift_correction_pkg::*;

    localparam int NL = 4;
    localparam int HW = 8;
    localparam int CW = 4;   // narrow counter so saturation is reachable quickly

    logic                      clk = 1'b0;
    logic                      arst;
    logic                      clk_en;
    logic                      scheduler_en;
    logic                      clear_state;
    logic [HW-1:0]             holdoff;
    logic [NL-1:0]             req;
    drift_direction_e [NL-1:0] dir;
    logic [NL-1:0]             ovf;
    logic [NL-1:0]             inv;
    logic [NL-1:0]             res;
    logic [NL-1:0]             fault;
    logic                      busy;
    logic [CW-1:0]             count;

    drift_correction_scheduler_if #(.LANE_W(2)) adj_if ();

    drift_correction_scheduler #(
        .NUM_LANES     (NL),
        .HOLDOFF_WIDTH (HW),
        .COUNT_WIDTH   (CW)
    ) dut (
        .clk                      (clk),
        .arst                     (arst),
        .clk_en                   (clk_en),
        .scheduler_en_i           (scheduler_en),
        .clear_state_i            (clear_state),
        .holdoff_cycles_i         (holdoff),
        .lane_drift_req_i         (req),
        .lane_drift_direction_i   (dir),
        .lane_overflow_i          (ovf),
        .lane_inverse_violation_i (inv),
        .lane_drift_res_o         (res),
        .lane_fault_o             (fault),
        .adj_if                   (adj_if),
        .busy_o                   (busy),
        .correction_count_o       (count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        logic [1:0]       lane;
        drift_direction_e dir;
    } exp_t;

    exp_t sb_q[$];
    int   hs_cnt = 0;
    int   hs_cyc = 0;

    task automatic push_exp(input logic [1:0] lane, input drift_direction_e d);
        exp_t e;
        e.lane = lane;
        e.dir  = d;
        sb_q.push_back(e);
    endtask

    // Every accept strobe must match the oldest expected correction.
    always @(negedge clk) begin
        exp_t e;
        if (!arst && res != '0) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_res", 32'(res), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("sb_res_onehot", 32'(res), 32'(4'b0001 << e.lane));
                check("sb_lane",       32'(adj_if.adj_lane_o), 32'(e.lane));
                check("sb_dir",        32'(adj_if.adj_direction_o), 32'(e.dir));
                check("sb_res_clk_en", 32'(clk_en), 32'd1);
            end
            hs_cnt++;
            hs_cyc = cyc;
        end
    end

    // ------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_lanes(input logic [NL-1:0] r, input logic [NL-1:0] late);
        req = r;
        for (int i = 0; i < NL; i++) begin
            dir[i] = late[i] ? PIN_CAME_LATE : PIN_CAME_EARLY;
        end
    endtask

    task automatic wait_hs(input int target, input int budget, input string name);
        for (int i = 0; i < budget && hs_cnt < target; i++) begin
            tick();
        end
        check(name, 32'(hs_cnt), 32'(target));
    endtask

    task automatic do_reset();
        arst         = 1'b1;
        clk_en       = 1'b1;
        scheduler_en = 1'b1;
        clear_state  = 1'b0;
        holdoff      = '0;
        ovf          = '0;
        inv          = '0;
        adj_if.adj_res_i = 1'b0;
        set_lanes('0, '0);
        tick();
        arst = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Transaction table: one grant per row, rr pointer carried across rows
    // ------------------------------------------------------------------
    typedef struct {
        logic [NL-1:0]    req;
        logic [NL-1:0]    late;
        logic [1:0]       exp_lane;
        drift_direction_e exp_dir;
        logic [CW-1:0]    exp_count;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int base;
        int last;
        int n;

        vecs[0] = '{4'b0100, 4'b0100, 2'd2, PIN_CAME_LATE,  4'd1};
        vecs[1] = '{4'b0011, 4'b0010, 2'd0, PIN_CAME_EARLY, 4'd2};
        vecs[2] = '{4'b0011, 4'b0010, 2'd1, PIN_CAME_LATE,  4'd3};
        vecs[3] = '{4'b1001, 4'b1000, 2'd3, PIN_CAME_LATE,  4'd4};
        vecs[4] = '{4'b1000, 4'b0000, 2'd3, PIN_CAME_EARLY, 4'd5};
        vecs[5] = '{4'b0110, 4'b0100, 2'd1, PIN_CAME_EARLY, 4'd6};

        // Reset values, observed while reset is held.
        arst = 1'b1;
        #1;
        check("rst_adj_req", 32'(adj_if.adj_req_o), 32'd0);
        check("rst_adj_lane", 32'(adj_if.adj_lane_o), 32'd0);
        check("rst_adj_dir", 32'(adj_if.adj_direction_o), 32'(PIN_CAME_EARLY));
        check("rst_res", 32'(res), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        do_reset();

        // Table: single grants, holdoff 0, generator always accepting.
        adj_if.adj_res_i = 1'b1;
        foreach (vecs[r]) begin
            set_lanes(vecs[r].req, vecs[r].late);
            push_exp(vecs[r].exp_lane, vecs[r].exp_dir);
            base = hs_cnt;
            tick();
            check("tbl_req_latency", 32'(adj_if.adj_req_o), 32'd1);
            check("tbl_grant_lane", 32'(adj_if.adj_lane_o), 32'(vecs[r].exp_lane));
            wait_hs(base + 1, 20, "tbl_handshake");
            req = '0;
            check("tbl_count", 32'(count), 32'(vecs[r].exp_count));
            tick();
            tick();
            check("tbl_idle", 32'(busy), 32'd0);
        end

        // All lanes requesting, holdoff 3: grants 0,1,2,3,0, five cycles apart.
        do_reset();
        holdoff = 8'd3;
        adj_if.adj_res_i = 1'b1;
        for (int g = 0; g < 5; g++) begin
            push_exp(2'(g % NL), PIN_CAME_EARLY);
        end
        set_lanes(4'b1111, 4'b0000);
        base = hs_cnt;
        last = 0;
        for (int g = 1; g <= 5; g++) begin
            wait_hs(base + g, 20, "rr_handshake");
            if (g > 1) begin
                check("rr_spacing", 32'(hs_cyc - last), 32'd5);
            end
            last = hs_cyc;
        end
        req = '0;
        check("rr_count", 32'(count), 32'd5);

        // Stalled generator: the grant stays frozen while the lane changes.
        do_reset();
        set_lanes(4'b0010, 4'b0000);
        tick();
        check("stall_req_up", 32'(adj_if.adj_req_o), 32'd1);
        for (int k = 0; k < 5; k++) begin
            set_lanes(4'b0000, (k % 2 == 0) ? 4'b0010 : 4'b0000);
            tick();
            check("stall_req", 32'(adj_if.adj_req_o), 32'd1);
            check("stall_lane", 32'(adj_if.adj_lane_o), 32'd1);
            check("stall_dir", 32'(adj_if.adj_direction_o), 32'(PIN_CAME_EARLY));
            check("stall_no_res", 32'(res), 32'd0);
        end
        push_exp(2'd1, PIN_CAME_EARLY);
        base = hs_cnt;
        adj_if.adj_res_i = 1'b1;
        wait_hs(base + 1, 10, "stall_handshake");
        check("stall_count", 32'(count), 32'd1);

        // Faults: overflowed lane 1 is fenced off until cleared.
        do_reset();
        scheduler_en = 1'b0;
        ovf = 4'b0010;
        tick();
        ovf = '0;
        check("flt_set", 32'(fault), 32'b0010);
        scheduler_en = 1'b1;
        adj_if.adj_res_i = 1'b1;
        set_lanes(4'b0011, 4'b0011);
        push_exp(2'd0, PIN_CAME_LATE);
        base = hs_cnt;
        wait_hs(base + 1, 10, "flt_lane0");
        set_lanes(4'b0010, 4'b0011);
        repeat (4) tick();
        check("flt_no_grant", 32'(hs_cnt), 32'(base + 1));
        check("flt_idle", 32'(busy), 32'd0);
        req = '0;
        ovf = 4'b0001;
        clear_state = 1'b1;
        tick();
        ovf = '0;
        clear_state = 1'b0;
        check("flt_clear_wins", 32'(fault), 32'd0);
        set_lanes(4'b0010, 4'b0010);
        push_exp(2'd1, PIN_CAME_LATE);
        wait_hs(base + 2, 10, "flt_lane1");
        req = '0;

        // Clock enable toggling: handshake and holdoff only on enabled cycles.
        do_reset();
        holdoff = 8'd2;
        adj_if.adj_res_i = 1'b1;
        set_lanes(4'b1000, 4'b1000);
        push_exp(2'd3, PIN_CAME_LATE);
        base = hs_cnt;
        for (int k = 0; k < 20 && hs_cnt == base; k++) begin
            tick();
            clk_en = ~clk_en;
            if (!clk_en) begin
                #1;
                check("cen_res_gated", 32'(res), 32'd0);
            end
        end
        check("cen_handshake", 32'(hs_cnt), 32'(base + 1));
        req = '0;
        n = 0;
        for (int k = 0; k < 20 && busy; k++) begin
            tick();
            clk_en = ~clk_en;
            n++;
        end
        check("cen_holdoff_len", 32'(n), 32'd4);
        clk_en = 1'b1;

        // Saturation, then asynchronous reset mid-HOLDOFF.
        do_reset();
        adj_if.adj_res_i = 1'b1;
        for (int g = 0; g < 17; g++) begin
            push_exp(2'd0, PIN_CAME_EARLY);
        end
        set_lanes(4'b0001, 4'b0000);
        base = hs_cnt;
        wait_hs(base + 17, 100, "sat_handshakes");
        req = '0;
        check("sat_count", 32'(count), 32'hF);
        holdoff = 8'd5;
        push_exp(2'd0, PIN_CAME_EARLY);
        set_lanes(4'b0001, 4'b0000);
        wait_hs(base + 18, 10, "sat_extra");
        req = '0;
        check("sat_count_hold", 32'(count), 32'hF);
        check("sat_in_holdoff", 32'(busy), 32'd1);
        #1;
        arst = 1'b1;
        #1;
        check("arst_hold_busy", 32'(busy), 32'd0);
        check("arst_hold_count", 32'(count), 32'd0);
        tick();
        arst = 1'b0;

        // Asynchronous reset mid-ISSUE drops the request without completion.
        adj_if.adj_res_i = 1'b0;
        inv = 4'b0100;
        tick();
        inv = '0;
        check("inv_fault", 32'(fault), 32'b0100);
        set_lanes(4'b1000, 4'b1000);
        tick();
        check("arst_issue_req", 32'(adj_if.adj_req_o), 32'd1);
        check("arst_issue_dir", 32'(adj_if.adj_direction_o), 32'(PIN_CAME_LATE));
        #1;
        arst = 1'b1;
        #1;
        check("arst_req", 32'(adj_if.adj_req_o), 32'd0);
        check("arst_lane", 32'(adj_if.adj_lane_o), 32'd0);
        check("arst_dir", 32'(adj_if.adj_direction_o), 32'(PIN_CAME_EARLY));
        check("arst_fault", 32'(fault), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_res", 32'(res), 32'd0);
        tick();
        req = '0;
        arst = 1'b0;
        tick();

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
